// File: rtl/instr_fetch_unit.sv
// Instruction fetch: drives the 8-bit instruction memory address, captures the byte into IR
// and offers it downstream through a single-entry valid/ready slot. Optional FETCH_PERF_CNT_EN adds counters.
module instr_fetch_unit #(
    parameter int         PROG_LEN = 32,
    parameter logic [7:0] RESET_PC = 8'h00
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic [7:0] mem_address,
    input  logic [7:0] mem_instruction,
    input  logic       redirect_valid,
    input  logic [7:0] redirect_target,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_pc,
    output logic [7:0] out_instruction,
    output logic [1:0] out_op,
    output logic [1:0] out_rs,
    output logic [1:0] out_rt,
    output logic [1:0] out_rd,
    output logic [7:0] out_imm,
    output logic       halted
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [15:0] perf_fetch_count,
    output logic [15:0] perf_stall_count
`endif
);

    // state  | meaning
    // S_IDLE | waiting for start, PC parked at RESET_PC
    // S_RUN  | fetching one byte per free slot
    // S_HALT | last program byte captured or redirected out of range; slot drains
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_t;

    localparam logic [8:0] LAST_PC  = 9'(PROG_LEN - 1);
    localparam logic [8:0] PROG_END = 9'(PROG_LEN);

    state_t     state;
    logic [7:0] pc;
    logic [7:0] ir;
    logic [7:0] ir_pc;
    logic       ir_valid;

    logic slot_free;
    logic redirect_take;
    logic capture;
    logic at_last;

    assign slot_free     = !ir_valid || out_ready;
    assign redirect_take = redirect_valid && (state == S_RUN || state == S_HALT);
    assign capture       = (state == S_RUN) && !redirect_valid && slot_free;
    // >= rather than == so a PC beyond the program can never keep fetching
    assign at_last       = ({1'b0, pc} >= LAST_PC);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            pc       <= RESET_PC;
            ir       <= 8'h00;
            ir_pc    <= 8'h00;
            ir_valid <= 1'b0;
        end else if (redirect_take) begin
            ir_valid <= 1'b0;
            pc       <= redirect_target;
            state    <= ({1'b0, redirect_target} < PROG_END) ? S_RUN : S_HALT;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) state <= S_RUN;
                end
                S_RUN: begin
                    if (capture) begin
                        ir       <= mem_instruction;
                        ir_pc    <= pc;
                        ir_valid <= 1'b1;
                        if (at_last) state <= S_HALT;
                        else         pc    <= pc + 8'd1;
                    end
                end
                S_HALT: begin
                    if (out_ready) ir_valid <= 1'b0;
                end
                default: begin
                    state    <= S_IDLE;
                    ir_valid <= 1'b0;
                end
            endcase
        end
    end

    assign mem_address     = pc;
    assign out_valid       = ir_valid;
    assign out_pc          = ir_pc;
    assign out_instruction = ir;
    assign out_op          = ir[7:6];
    assign out_rs          = ir[5:4];
    assign out_rt          = ir[3:2];
    assign out_rd          = ir[1:0];
    assign out_imm         = {{6{ir[1]}}, ir[1:0]};
    assign halted          = (state == S_HALT);

`ifdef FETCH_PERF_CNT_EN
    logic stall;
    assign stall = (state == S_RUN) && ir_valid && !out_ready;

    // both counters saturate and survive redirects
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetch_count <= 16'h0000;
            perf_stall_count <= 16'h0000;
        end else begin
            if (capture && perf_fetch_count != 16'hFFFF)
                perf_fetch_count <= perf_fetch_count + 16'd1;
            if (stall && perf_stall_count != 16'hFFFF)
                perf_stall_count <= perf_stall_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit (PROG_LEN=5): vector table for streaming/backpressure,
// hand sequences for redirect, priority, async reset and sign extension.
module tb_instr_fetch_unit;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       redirect_valid = 1'b0;
    logic [7:0] redirect_target = 8'h00;
    logic       out_ready = 1'b0;
    logic [7:0] mem_address;
    logic [7:0] mem_instruction;
    logic       out_valid;
    logic [7:0] out_pc;
    logic [7:0] out_instruction;
    logic [1:0] out_op, out_rs, out_rt, out_rd;
    logic [7:0] out_imm;
    logic       halted;
`ifdef FETCH_PERF_CNT_EN
    logic [15:0] perf_fetch_count;
    logic [15:0] perf_stall_count;
`endif

    logic [7:0] mem [256];
    assign mem_instruction = mem[mem_address];

    always #5 clk = ~clk;

    instr_fetch_unit #(.PROG_LEN(5), .RESET_PC(8'h00)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start           (start),
        .mem_address     (mem_address),
        .mem_instruction (mem_instruction),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_pc          (out_pc),
        .out_instruction (out_instruction),
        .out_op          (out_op),
        .out_rs          (out_rs),
        .out_rt          (out_rt),
        .out_rd          (out_rd),
        .out_imm         (out_imm),
        .halted          (halted)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_fetch_count(perf_fetch_count),
        .perf_stall_count(perf_stall_count)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic       start;
        logic       ready;
        logic       v;
        logic [7:0] pc;
        logic [7:0] ins;
        logic [7:0] addr;
        logic [7:0] imm;
        logic       h;
    } vec_t;

    vec_t vecs [11];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [7:0] pc,
                           input logic [7:0] ins, input logic [7:0] addr, input logic h);
        chk({tag, ".valid"}, 16'(out_valid), 16'(v));
        chk({tag, ".out_pc"}, 16'(out_pc), 16'(pc));
        chk({tag, ".instr"}, 16'(out_instruction), 16'(ins));
        chk({tag, ".mem_addr"}, 16'(mem_address), 16'(addr));
        chk({tag, ".halted"}, 16'(halted), 16'(h));
    endtask

    task automatic drive(input logic rv, input logic [7:0] tgt, input logic rdy);
        redirect_valid  = rv;
        redirect_target = tgt;
        out_ready       = rdy;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[0] = 8'h49; mem[1] = 8'hC1; mem[2] = 8'h18; mem[3] = 8'hA9; mem[4] = 8'h4D;

        //            start rdy  v     pc     ins    addr   imm    h
        vecs[0]  = '{1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0};
        vecs[1]  = '{1'b0, 1'b1, 1'b1, 8'h00, 8'h49, 8'h01, 8'h01, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 1'b1, 8'h01, 8'hC1, 8'h02, 8'h01, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 1'b1, 8'h01, 8'hC1, 8'h02, 8'h01, 1'b0};
        vecs[4]  = '{1'b0, 1'b0, 1'b1, 8'h01, 8'hC1, 8'h02, 8'h01, 1'b0};
        vecs[5]  = '{1'b0, 1'b0, 1'b1, 8'h01, 8'hC1, 8'h02, 8'h01, 1'b0};
        vecs[6]  = '{1'b0, 1'b1, 1'b1, 8'h02, 8'h18, 8'h03, 8'h00, 1'b0};
        vecs[7]  = '{1'b0, 1'b1, 1'b1, 8'h03, 8'hA9, 8'h04, 8'h01, 1'b0};
        vecs[8]  = '{1'b0, 1'b1, 1'b1, 8'h04, 8'h4D, 8'h04, 8'h01, 1'b1};
        vecs[9]  = '{1'b0, 1'b1, 1'b0, 8'h04, 8'h4D, 8'h04, 8'h01, 1'b1};
        vecs[10] = '{1'b1, 1'b1, 1'b0, 8'h04, 8'h4D, 8'h04, 8'h01, 1'b1};

        #3;
        chk_out("reset", 1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
        chk("reset.imm", 16'(out_imm), 16'h0000);
        chk("reset.op", 16'(out_op), 16'h0000);
        #9 rst_n = 1'b1;

        for (int i = 0; i < 11; i++) begin
            start     = vecs[i].start;
            out_ready = vecs[i].ready;
            step();
            chk_out($sformatf("vec%0d", i), vecs[i].v, vecs[i].pc, vecs[i].ins, vecs[i].addr, vecs[i].h);
            chk($sformatf("vec%0d.imm", i), 16'(out_imm), 16'(vecs[i].imm));
        end
        start = 1'b0;
`ifdef FETCH_PERF_CNT_EN
        chk("perf_fetch", perf_fetch_count, 16'd5);
        chk("perf_stall", perf_stall_count, 16'd3);
`endif

        // redirect out of range / boundary / into the last byte
        drive(1'b1, 8'h05, 1'b1); step(); chk_out("redir5", 1'b0, 8'h04, 8'h4D, 8'h05, 1'b1);
        drive(1'b1, 8'h07, 1'b1); step(); chk_out("redir7", 1'b0, 8'h04, 8'h4D, 8'h07, 1'b1);
        drive(1'b1, 8'h04, 1'b1); step(); chk_out("redir4", 1'b0, 8'h04, 8'h4D, 8'h04, 1'b0);
        drive(1'b0, 8'h00, 1'b1); step(); chk_out("last", 1'b1, 8'h04, 8'h4D, 8'h04, 1'b1);

        // redirect from HALT with a stalled entry, then stream and decode fields
        drive(1'b1, 8'h00, 1'b0); step(); chk_out("restart", 1'b0, 8'h04, 8'h4D, 8'h00, 1'b0);
        drive(1'b0, 8'h00, 1'b1); step(); chk_out("s0", 1'b1, 8'h00, 8'h49, 8'h01, 1'b0);
        chk("dec.op", 16'(out_op), 16'h1);
        chk("dec.rs", 16'(out_rs), 16'h0);
        chk("dec.rt", 16'(out_rt), 16'h2);
        chk("dec.rd", 16'(out_rd), 16'h1);
        chk("dec.imm", 16'(out_imm), 16'h01);
        step(); chk_out("s1", 1'b1, 8'h01, 8'hC1, 8'h02, 1'b0);
        step(); chk_out("s2", 1'b1, 8'h02, 8'h18, 8'h03, 1'b0);
        step(); chk_out("s3", 1'b1, 8'h03, 8'hA9, 8'h04, 1'b0);
        chk("s3.imm", 16'(out_imm), 16'h01);

        // flush while holding address 3
        drive(1'b1, 8'h00, 1'b0); step(); chk_out("flush", 1'b0, 8'h03, 8'hA9, 8'h00, 1'b0);
        drive(1'b0, 8'h00, 1'b1); step(); chk_out("flush.next", 1'b1, 8'h00, 8'h49, 8'h01, 1'b0);

        // redirect, valid and ready together: flush wins, no capture
        drive(1'b1, 8'h02, 1'b1); step(); chk_out("prio", 1'b0, 8'h00, 8'h49, 8'h02, 1'b0);
        drive(1'b0, 8'h00, 1'b1); step(); chk_out("prio.next", 1'b1, 8'h02, 8'h18, 8'h03, 1'b0);

        // async reset in the middle of a stall
        out_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk_out("async_rst", 1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
        chk("async_rst.imm", 16'(out_imm), 16'h0000);
        #1 rst_n = 1'b1;
        drive(1'b0, 8'h00, 1'b1); step(); chk_out("idle", 1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
        drive(1'b1, 8'h03, 1'b1); step(); chk_out("idle.redir", 1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
        drive(1'b0, 8'h00, 1'b1);
        start = 1'b1; step(); chk_out("rs.start", 1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
        start = 1'b0; step(); chk_out("rs.first", 1'b1, 8'h00, 8'h49, 8'h01, 1'b0);

        // sign extension of rd
        mem[0] = 8'h4F; mem[1] = 8'h4E;
        drive(1'b1, 8'h00, 1'b1); step(); chk_out("sx.flush", 1'b0, 8'h00, 8'h49, 8'h00, 1'b0);
        drive(1'b0, 8'h00, 1'b1); step();
        chk("sx.4F.instr", 16'(out_instruction), 16'h4F);
        chk("sx.4F.imm", 16'(out_imm), 16'hFF);
        step();
        chk("sx.4E.instr", 16'(out_instruction), 16'h4E);
        chk("sx.4E.imm", 16'(out_imm), 16'hFE);
        chk("sx.4E.pc", 16'(out_pc), 16'h01);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
